// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store size codes and a size decoder.
package store_buffer_pkg;

  typedef enum logic [2:0] {
    DM_BYTE  = 3'd0,
    DM_HALF  = 3'd1,
    DM_WORD  = 3'd2,
    DM_DWORD = 3'd3
  } dm_op_e;

  // Store size in bytes for a size code; 0 marks a reserved code.
  function automatic logic [3:0] dm_size(input logic [2:0] op);
    logic [3:0] size;
    case (op)
      DM_BYTE:  size = 4'd1;
      DM_HALF:  size = 4'd2;
      DM_WORD:  size = 4'd4;
      DM_DWORD: size = 4'd8;
      default:  size = 4'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/sb_lane_align.sv
// Byte-lane alignment of a store request: byte enables, shifted write data
// and the misalignment flag. Purely combinational.
module sb_lane_align
  import store_buffer_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic [31:0]               i_addr,
  input  logic [8*WORD_BYTES-1:0]   i_data,
  input  logic [2:0]                i_op,
  output logic [WORD_BYTES-1:0]     o_byteen,
  output logic [8*WORD_BYTES-1:0]   o_wdata,
  output logic                      o_misaligned
);

  localparam int W   = 8 * WORD_BYTES;
  localparam int OFF = $clog2(WORD_BYTES);

  logic [3:0]            w_size;
  logic [OFF-1:0]        w_lane;
  logic [8:0]            w_mask9;
  logic [WORD_BYTES-1:0] w_low_be;
  logic [W-1:0]          w_data_mask;
  logic                  w_mis;

  // Per-byte data mask covering the stored low bytes of the register value.
  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_dmask
    assign w_data_mask[8*g +: 8] = {8{w_low_be[g]}};
  end

  // Decode size, lane, alignment and shift enables/data into their lanes.
  always_comb begin
    w_size   = dm_size(i_op);
    w_lane   = i_addr[OFF-1:0];
    w_mask9  = (9'd1 << w_size) - 9'd1;
    w_low_be = w_mask9[WORD_BYTES-1:0];
    // Reserved codes decode to size 0 and are always rejected.
    w_mis    = (w_size == 4'd0) ||
               (w_size > 4'(WORD_BYTES)) ||
               ((i_addr & {28'd0, (w_size - 4'd1)}) != 32'd0);
    if (w_mis) begin
      o_byteen = {WORD_BYTES{1'b0}};
      o_wdata  = {W{1'b0}};
    end else begin
      o_byteen = w_low_be << w_lane;
      o_wdata  = (i_data & w_data_mask) << {w_lane, 3'b000};
    end
    o_misaligned = w_mis;
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: aligns stores, merges
// same-word stores into the tail entry and drains a FIFO to memory.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 4,
  parameter int MERGE_EN   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 req_addr,
  input  logic [8*WORD_BYTES-1:0]     req_data,
  input  logic [2:0]                  req_op,
  output logic                        req_err,
  output logic                        m_data_valid,
  input  logic                        m_data_ready,
  output logic [31:0]                 m_data_addr,
  output logic [WORD_BYTES-1:0]       m_data_byteen,
  output logic [8*WORD_BYTES-1:0]     m_data_wdata,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int W   = 8 * WORD_BYTES;
  localparam int OFF = $clog2(WORD_BYTES);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]           r_addr [DEPTH];
  logic [WORD_BYTES-1:0] r_be   [DEPTH];
  logic [W-1:0]          r_data [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic [WORD_BYTES-1:0] w_be;
  logic [W-1:0]          w_wdata;
  logic [W-1:0]          w_mask;
  logic                  w_mis;
  logic [31:0]           w_word_addr;
  logic [PW-1:0]         w_tail_last;
  logic                  w_nonempty;
  logic                  w_merge_cand;
  logic                  w_merge_hit;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_merge;
  logic                  w_new;

  sb_lane_align #(.WORD_BYTES(WORD_BYTES)) u_align (
    .i_addr       (req_addr),
    .i_data       (req_data),
    .i_op         (req_op),
    .o_byteen     (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis)
  );

  for (genvar g = 0; g < WORD_BYTES; g++) begin : g_mmask
    assign w_mask[8*g +: 8] = {8{w_be[g]}};
  end

  assign w_word_addr = {req_addr[31:OFF], {OFF{1'b0}}};
  assign w_tail_last = r_tail - PW'(1);
  assign w_nonempty  = (r_count != {CW{1'b0}});
  assign w_pop       = w_nonempty && m_data_ready;

  // Merge candidate ignores the pop so req_ready never sees m_data_ready;
  // the only excluded case (count==1 popping) already has room for a new entry.
  assign w_merge_cand = (MERGE_EN != 0) && w_nonempty &&
                        (r_addr[w_tail_last] == w_word_addr);
  assign w_merge_hit  = w_merge_cand && !(w_pop && (r_count == CW'(1)));

  assign req_ready = (r_count < DEPTH_C) || w_merge_cand || w_mis;
  assign req_err   = req_valid && w_mis;
  assign w_push    = req_valid && req_ready && !w_mis;
  assign w_merge   = w_push && w_merge_hit;
  assign w_new     = w_push && !w_merge_hit;

  assign m_data_valid  = w_nonempty;
  assign m_data_addr   = w_nonempty ? r_addr[r_head] : 32'd0;
  assign m_data_byteen = w_nonempty ? r_be[r_head]   : {WORD_BYTES{1'b0}};
  assign m_data_wdata  = w_nonempty ? r_data[r_head] : {W{1'b0}};
  assign count         = r_count;

  // Entry storage: write a fresh tail entry or merge lanes into the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 32'd0;
        r_be[i]   <= {WORD_BYTES{1'b0}};
        r_data[i] <= {W{1'b0}};
      end
    end else begin
      if (w_new) begin
        r_addr[r_tail] <= w_word_addr;
        r_be[r_tail]   <= w_be;
        r_data[r_tail] <= w_wdata;
      end
      if (w_merge) begin
        r_be[w_tail_last]   <= r_be[w_tail_last] | w_be;
        r_data[w_tail_last] <= (r_data[w_tail_last] & ~w_mask) | w_wdata;
      end
    end
  end

  // Head/tail pointers and occupancy; merges leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_new) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_new) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit word instance
  logic        req_valid, req_ready, req_err, m_valid, m_ready;
  logic [31:0] req_addr, req_data, m_addr, m_wdata;
  logic [2:0]  req_op;
  logic [3:0]  m_be;
  logic [2:0]  cnt;

  // 64-bit word instance
  logic        v8, rdy8, err8, mv8, mr8;
  logic [31:0] a8, ma8;
  logic [63:0] d8, mw8;
  logic [2:0]  op8;
  logic [7:0]  mb8;
  logic [2:0]  cnt8;

  store_buffer #(.WORD_BYTES(4), .DEPTH(DEPTH), .MERGE_EN(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_op(req_op), .req_err(req_err),
    .m_data_valid(m_valid), .m_data_ready(m_ready), .m_data_addr(m_addr),
    .m_data_byteen(m_be), .m_data_wdata(m_wdata), .count(cnt)
  );

  store_buffer #(.WORD_BYTES(8), .DEPTH(DEPTH), .MERGE_EN(1)) dut8 (
    .clk(clk), .reset(reset),
    .req_valid(v8), .req_ready(rdy8), .req_addr(a8),
    .req_data(d8), .req_op(op8), .req_err(err8),
    .m_data_valid(mv8), .m_data_ready(mr8), .m_data_addr(ma8),
    .m_data_byteen(mb8), .m_data_wdata(mw8), .count(cnt8)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
  } ent_t;
  ent_t mq[$];

  function automatic void ref_align(input logic [31:0] a, input logic [63:0] d,
                                    input logic [2:0] op, input int wb,
                                    output bit mis, output logic [7:0] be,
                                    output logic [63:0] wd);
    int size, lane;
    logic [63:0] m;
    if (op > 3'd3) begin
      mis = 1'b1; be = 8'd0; wd = 64'd0;
      return;
    end
    size = 1 << op;
    lane = int'(a % wb);
    mis  = (size > wb) || ((a % size) != 0);
    be   = 8'((1 << size) - 1) << lane;
    m    = (size == 8) ? d : (d & ((64'd1 << (8 * size)) - 64'd1));
    wd   = m << (8 * lane);
    if (mis) begin
      be = 8'd0; wd = 64'd0;
    end
  endfunction

  task automatic drv(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    req_valid = v; req_addr = a; req_data = d; req_op = op;
  endtask

  // Check outputs against the model for the driven inputs, then advance one edge.
  task automatic cyc(input string tag);
    bit mis, cand, pop, hit, exp_ready, push;
    logic [7:0] be;
    logic [63:0] wd;
    logic [31:0] word;
    int n;
    ent_t e;
    #1;
    ref_align(req_addr, {32'd0, req_data}, req_op, 4, mis, be, wd);
    word = req_addr & ~32'd3;
    n = mq.size();
    cand = (n != 0) && (mq[n-1].addr == word);
    pop  = (n != 0) && m_ready;
    hit  = cand && !(pop && n == 1);
    exp_ready = (n < DEPTH) || cand || mis;
    chk({tag, " req_ready"}, 64'(req_ready), 64'(exp_ready));
    chk({tag, " req_err"}, 64'(req_err), 64'(req_valid && mis));
    chk({tag, " count"}, 64'(cnt), 64'(n));
    chk({tag, " m_valid"}, 64'(m_valid), 64'(n != 0));
    chk({tag, " m_addr"}, 64'(m_addr), (n != 0) ? 64'(mq[0].addr) : 64'd0);
    chk({tag, " m_byteen"}, 64'(m_be), (n != 0) ? 64'(mq[0].be) : 64'd0);
    chk({tag, " m_wdata"}, 64'(m_wdata), (n != 0) ? mq[0].data : 64'd0);
    push = req_valid && exp_ready && !mis;
    if (push && hit) begin
      e = mq[n-1];
      e.be = e.be | be;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) e.data[8*b +: 8] = wd[8*b +: 8];
      end
      mq[n-1] = e;
    end
    if (pop) void'(mq.pop_front());
    if (push && !hit) mq.push_back('{word, be, wd});
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
    bit          err;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;
  vec_t tbl[9];

  initial begin
    bit acc;
    int k, guard, r;

    tbl[0] = '{32'h100, 32'h12345678, DM_WORD,  1'b0, 4'hF, 32'h12345678};
    tbl[1] = '{32'h101, 32'hDEADBEEF, DM_BYTE,  1'b0, 4'h2, 32'h0000EF00};
    tbl[2] = '{32'h102, 32'hCAFEBABE, DM_HALF,  1'b0, 4'hC, 32'hBABE0000};
    tbl[3] = '{32'h103, 32'h000000A5, DM_BYTE,  1'b0, 4'h8, 32'hA5000000};
    tbl[4] = '{32'h103, 32'h0000CDEF, DM_HALF,  1'b1, 4'h0, 32'h0};
    tbl[5] = '{32'h102, 32'h11111111, DM_WORD,  1'b1, 4'h0, 32'h0};
    tbl[6] = '{32'h100, 32'h22222222, 3'd5,     1'b1, 4'h0, 32'h0};
    tbl[7] = '{32'h100, 32'h33333333, DM_DWORD, 1'b1, 4'h0, 32'h0};
    tbl[8] = '{32'h104, 32'h1234ABCD, DM_HALF,  1'b0, 4'h3, 32'h0000ABCD};

    reset = 1'b1;
    drv(1'b0, 32'd0, 32'd0, DM_BYTE);
    m_ready = 1'b0;
    v8 = 1'b0; a8 = 32'd0; d8 = 64'd0; op8 = DM_BYTE; mr8 = 1'b1;
    #12;
    chk("reset count", 64'(cnt), 64'd0);
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset m_addr", 64'(m_addr), 64'd0);
    chk("reset m_byteen", 64'(m_be), 64'd0);
    chk("reset m_wdata", 64'(m_wdata), 64'd0);
    chk("reset count8", 64'(cnt8), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven single stores into an empty buffer with ready memory.
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, tbl[i].addr, tbl[i].data, tbl[i].op);
      #1;
      chk($sformatf("vec%0d req_err", i), 64'(req_err), 64'(tbl[i].err));
      chk($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      drv(1'b0, 32'd0, 32'd0, DM_BYTE);
      #1;
      chk($sformatf("vec%0d count", i), 64'(cnt), tbl[i].err ? 64'd0 : 64'd1);
      if (!tbl[i].err) begin
        chk($sformatf("vec%0d m_addr", i), 64'(m_addr), 64'(tbl[i].addr & ~32'd3));
        chk($sformatf("vec%0d m_byteen", i), 64'(m_be), 64'(tbl[i].be));
        chk($sformatf("vec%0d m_wdata", i), 64'(m_wdata), 64'(tbl[i].wd));
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d drained", i), 64'(cnt), 64'd0);
    end

    // Merge into a waiting head entry.
    m_ready = 1'b0;
    drv(1'b1, 32'h201, 32'hAB, DM_BYTE);   cyc("merge_sb");
    drv(1'b1, 32'h202, 32'hCDEF, DM_HALF); cyc("merge_sh");
    drv(1'b0, 32'd0, 32'd0, DM_BYTE);
    #1;
    chk("merge count", 64'(cnt), 64'd1);
    chk("merge m_addr", 64'(m_addr), 64'h200);
    chk("merge m_byteen", 64'(m_be), 64'hE);
    chk("merge m_wdata", 64'(m_wdata), 64'hCDEFAB00);
    m_ready = 1'b1;
    cyc("merge_drain");

    // Fill, stall on full, merge into the full tail, then wrap the pointers.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'h300 + 32'(4 * i), 32'(i + 1), DM_BYTE);
      cyc("fill");
    end
    drv(1'b1, 32'h310, 32'h55, DM_BYTE);
    #1;
    chk("full count", 64'(cnt), 64'd4);
    chk("full stall ready", 64'(req_ready), 64'd0);
    cyc("full_stall");
    drv(1'b1, 32'h30D, 32'h66, DM_BYTE);
    #1;
    chk("full merge ready", 64'(req_ready), 64'd1);
    cyc("full_merge");
    m_ready = 1'b1;
    k = 0; guard = 0;
    while (k < 8 && guard < 40) begin
      drv(1'b1, 32'h400 + 32'(4 * k), 32'hA0000000 + 32'(k), DM_WORD);
      #1;
      acc = req_ready;
      cyc("wrap");
      if (acc) k++;
      guard++;
    end
    chk("wrap all accepted", 64'(k), 64'd8);
    drv(1'b0, 32'd0, 32'd0, DM_BYTE);
    for (int i = 0; i < 6; i++) cyc("wrap_drain");
    chk("wrap empty", 64'(cnt), 64'd0);

    // Same-word store while the single entry pops: two separate writes.
    m_ready = 1'b0;
    drv(1'b1, 32'h500, 32'h11223344, DM_WORD); cyc("pm_first");
    m_ready = 1'b1;
    drv(1'b1, 32'h502, 32'hBEEF, DM_HALF);
    #1;
    chk("pm ready", 64'(req_ready), 64'd1);
    chk("pm head be", 64'(m_be), 64'hF);
    cyc("pm_push");
    drv(1'b0, 32'd0, 32'd0, DM_BYTE);
    #1;
    chk("pm count", 64'(cnt), 64'd1);
    chk("pm m_addr", 64'(m_addr), 64'h500);
    chk("pm m_byteen", 64'(m_be), 64'hC);
    chk("pm m_wdata", 64'(m_wdata), 64'hBEEF0000);
    cyc("pm_drain");

    // Asynchronous reset with three queued entries.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 32'h700 + 32'(4 * i), 32'hFF, DM_BYTE);
      cyc("rst_fill");
    end
    drv(1'b0, 32'd0, 32'd0, DM_BYTE);
    #1;
    chk("pre-reset count", 64'(cnt), 64'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("mid reset count", 64'(cnt), 64'd0);
    chk("mid reset m_valid", 64'(m_valid), 64'd0);
    chk("mid reset m_addr", 64'(m_addr), 64'd0);
    chk("mid reset m_byteen", 64'(m_be), 64'd0);
    chk("mid reset m_wdata", 64'(m_wdata), 64'd0);
    mq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 64-bit word variant.
    v8 = 1'b1; a8 = 32'h108; d8 = 64'h1122334455667788; op8 = DM_DWORD;
    #1;
    chk("sd8 err", 64'(err8), 64'd0);
    chk("sd8 ready", 64'(rdy8), 64'd1);
    @(posedge clk); #1;
    v8 = 1'b0;
    #1;
    chk("sd8 count", 64'(cnt8), 64'd1);
    chk("sd8 m_addr", 64'(ma8), 64'h108);
    chk("sd8 m_byteen", 64'(mb8), 64'hFF);
    chk("sd8 m_wdata", mw8, 64'h1122334455667788);
    @(posedge clk); #1;
    v8 = 1'b1; a8 = 32'h104; d8 = 64'hCAFEF00D12345678; op8 = DM_WORD;
    #1;
    chk("sw8 err", 64'(err8), 64'd0);
    @(posedge clk); #1;
    v8 = 1'b0;
    #1;
    chk("sw8 m_addr", 64'(ma8), 64'h100);
    chk("sw8 m_byteen", 64'(mb8), 64'hF0);
    chk("sw8 m_wdata", mw8, 64'h1234567800000000);
    @(posedge clk); #1;
    v8 = 1'b1; a8 = 32'h104; op8 = DM_DWORD;
    #1;
    chk("sd8 mis err", 64'(err8), 64'd1);
    chk("sd8 mis ready", 64'(rdy8), 64'd1);
    @(posedge clk); #1;
    v8 = 1'b0;
    #1;
    chk("sd8 mis count", 64'(cnt8), 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      drv($urandom_range(0, 3) != 0, 32'h600 + 32'($urandom_range(0, 15)), $urandom,
          (r < 4) ? DM_BYTE : (r < 7) ? DM_HALF : (r < 9) ? DM_WORD : 3'd5);
      m_ready = ($urandom_range(0, 3) != 0);
      cyc("rand");
    end
    drv(1'b0, 32'd0, 32'd0, DM_BYTE);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc("rand_drain");
    chk("final empty", 64'(cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
